// File: rtl/cond_sum_pkg.sv
// Shared types and elaboration helpers for the pipelined conditional-sum adder.
package cond_sum_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bits resolved per pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Legal when the operand splits into STAGES equal, non-empty chunks.
  function automatic bit width_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/cond_sum_pipe_adder_if.sv
// Request/result handshake bundle for cond_sum_pipe_adder.
interface cond_sum_pipe_adder_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
   );
endinterface

// File: rtl/cond_sum_chunk.sv
// Dual-carry chunk adder: both carry-in hypotheses computed, then selected.
module cond_sum_chunk #(
   parameter int unsigned CW = 16
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin_sel,
   output logic [CW-1:0] sum,
   output logic          cout
);
   logic [CW:0] sum0;
   logic [CW:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + (CW+1)'(1);

   assign {cout, sum} = cin_sel ? sum1 : sum0;
endmodule

// File: rtl/cond_sum_pipe_adder.sv
// Pipelined conditional-sum adder/subtractor: one chunk per stage, carry and
// unresolved operand chunks skewed forward, valid/ready backpressure per stage.
module cond_sum_pipe_adder
   import cond_sum_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   cond_sum_pipe_adder_if.slave bus
);
   localparam int unsigned CW = chunk_width(WIDTH, STAGES);

   if (!width_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("cond_sum_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // RW: operand bits still unresolved entering this stage; SW: result bits after it.
      localparam int unsigned RW = WIDTH - k * CW;
      localparam int unsigned SW = (k + 1) * CW;

      logic             v_q;
      logic             c_q;
      logic             ld;
      logic [SW-1:0]    s_q;
      logic [TAG_W-1:0] t_q;

      logic             v_d;
      logic             c_d;
      logic [RW-1:0]    a_d;
      logic [RW-1:0]    b_d;
      logic [SW-1:0]    s_nx;
      logic [TAG_W-1:0] t_d;
      logic [CW-1:0]    ch_sum;
      logic             ch_cout;

      cond_sum_chunk #(.CW(CW)) u_chunk (
         .a       (a_d[CW-1:0]),
         .b       (b_d[CW-1:0]),
         .cin_sel (c_d),
         .sum     (ch_sum),
         .cout    (ch_cout)
      );

      if (k == 0) begin : g_head
         op_e op;
         assign op   = op_e'(bus.in_sub);
         assign v_d  = bus.in_valid;
         assign a_d  = bus.in_a;
         assign b_d  = (op == OP_SUB) ? ~bus.in_b : bus.in_b;
         assign c_d  = (op == OP_SUB) ? 1'b1 : bus.in_cin;
         assign t_d  = bus.in_tag;
         assign s_nx = ch_sum;
      end else begin : g_body
         assign v_d  = g_st[k-1].v_q;
         assign a_d  = g_st[k-1].g_mid.a_q;
         assign b_d  = g_st[k-1].g_mid.b_q;
         assign c_d  = g_st[k-1].c_q;
         assign t_d  = g_st[k-1].t_q;
         assign s_nx = {ch_sum, g_st[k-1].s_q};
      end

      // Stage register: loads when empty or when its contents move on.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
            t_q <= '0;
         end else if (ld) begin
            v_q <= v_d;
            c_q <= ch_cout;
            s_q <= s_nx;
            t_q <= t_d;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [RW-CW-1:0] a_q;
         logic [RW-CW-1:0] b_q;

         assign ld = !v_q || g_st[k+1].ld;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ld) begin
               a_q <= a_d[RW-1:CW];
               b_q <= b_d[RW-1:CW];
            end
         end
      end else begin : g_last
         logic ovf_q;

         assign ld = !v_q || bus.out_ready;

         // Top chunk holds the operand MSBs, so overflow resolves here.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (ld) begin
               ovf_q <= (a_d[CW-1] == b_d[CW-1]) && (ch_sum[CW-1] != a_d[CW-1]);
            end
         end

         assign bus.out_valid = v_q;
         assign bus.out_sum   = s_q;
         assign bus.out_cout  = c_q;
         assign bus.out_ovf   = ovf_q;
         assign bus.out_tag   = t_q;
      end
   end

   assign bus.in_ready = g_st[0].ld;
endmodule

// File: tb/tb_cond_sum_pipe_adder.sv
// Bench for cond_sum_pipe_adder: directed cases plus randomized traffic scored
// against an arithmetic reference model.
module tb_cond_sum_pipe_adder;
   localparam int unsigned W = 64;
   localparam int unsigned S = 4;
   localparam int unsigned T = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cond_sum_pipe_adder_if #(.WIDTH(W), .TAG_W(T)) bus ();

   cond_sum_pipe_adder #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic [T-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t me;
   int   total = 0;
   int   bad = 0;
   int   out_cnt = 0;

   logic         held = 1'b0;
   logic [W-1:0] h_sum;
   logic         h_cout, h_ovf;
   logic [T-1:0] h_tag;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Reference: plain unsigned / signed arithmetic on wide integers.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input logic [T-1:0] tag);
      exp_t e;
      logic signed [W+1:0] sa, sb, sc, sr, hi, lo;
      logic [W:0] u;
      sa = $signed({{2{a[W-1]}}, a});
      sb = $signed({{2{b[W-1]}}, b});
      sc = cin ? 1 : 0;
      hi = {3'b000, {(W-1){1'b1}}};
      lo = {3'b111, {(W-1){1'b0}}};
      if (sub) begin
         e.sum  = a - b;
         e.cout = (a >= b);
         sr     = sa - sb;
      end else begin
         u      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         e.sum  = u[W-1:0];
         e.cout = u[W];
         sr     = sa + sb + sc;
      end
      e.ovf = (sr > hi) || (sr < lo);
      e.tag = tag;
      return e;
   endfunction

   function automatic logic [W-1:0] rnd64();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'({$urandom(), $urandom()});
      endcase
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [T-1:0] tag);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
      bus.in_tag   = tag;
   endtask

   task automatic drive_rnd(input logic v, input logic [T-1:0] tag);
      drive(v, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
   endtask

   // Scoreboard: sampled just before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", 128'(bus.out_valid), 128'(1'b1));
            chk("stall_sum", 128'(bus.out_sum), 128'(h_sum));
            chk("stall_flags", 128'({bus.out_cout, bus.out_ovf}), 128'({h_cout, h_ovf}));
            chk("stall_tag", 128'(bus.out_tag), 128'(h_tag));
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", 128'(exp_q.size() > 0), 128'(1'b1));
            if (exp_q.size() > 0) begin
               me = exp_q.pop_front();
               chk("sb_sum", 128'(bus.out_sum), 128'(me.sum));
               chk("sb_cout", 128'(bus.out_cout), 128'(me.cout));
               chk("sb_ovf", 128'(bus.out_ovf), 128'(me.ovf));
               chk("sb_tag", 128'(bus.out_tag), 128'(me.tag));
            end
            out_cnt++;
         end
         held   = bus.out_valid && !bus.out_ready;
         h_sum  = bus.out_sum;
         h_cout = bus.out_cout;
         h_ovf  = bus.out_ovf;
         h_tag  = bus.out_tag;
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, bus.in_tag));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Single op through an empty pipe with out_ready=1; checks latency and value.
   task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input logic [T-1:0] tag, input logic [W-1:0] esum,
                           input logic ecout, input logic eovf, input string name);
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(1'b1, a, b, cin, sub, tag);
      #1 chk({name, "_in_ready"}, 128'(bus.in_ready), 128'(1'b1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (S - 2) @(negedge clk);
      chk({name, "_early"}, 128'(bus.out_valid), 128'(1'b0));
      @(negedge clk);
      chk({name, "_valid"}, 128'(bus.out_valid), 128'(1'b1));
      chk({name, "_sum"}, 128'(bus.out_sum), 128'(esum));
      chk({name, "_cout"}, 128'(bus.out_cout), 128'(ecout));
      chk({name, "_ovf"}, 128'(bus.out_ovf), 128'(eovf));
      chk({name, "_tag"}, 128'(bus.out_tag), 128'(tag));
   endtask

   task automatic wait_idle(input int lim, input string name);
      for (int i = 0; i < lim && (exp_q.size() != 0 || bus.out_valid); i++) @(negedge clk);
      chk({name, "_queue"}, 128'(exp_q.size()), 128'(0));
      chk({name, "_valid"}, 128'(bus.out_valid), 128'(1'b0));
   endtask

   initial begin
      int acc, drop_inflight, base, stalls, misses, stale;

      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
      chk("rst_out_sum", 128'(bus.out_sum), 128'(0));
      chk("rst_out_cout", 128'(bus.out_cout), 128'(1'b0));
      chk("rst_out_ovf", 128'(bus.out_ovf), 128'(1'b0));
      chk("rst_out_tag", 128'(bus.out_tag), 128'(0));
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));

      directed('1, 64'd1, 1'b0, 1'b0, 4'd3, 64'd0, 1'b1, 1'b0, "add_ripple");
      directed(64'd5, 64'd7, 1'b0, 1'b1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
      directed(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4'd2,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub_ovf");
      directed(64'd0, 64'd0, 1'b1, 1'b0, 4'd4, 64'd1, 1'b0, 1'b0, "cin_one");
      directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd5,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, "add_ovf");
      directed(64'd9, 64'd9, 1'b1, 1'b1, 4'd6, 64'd0, 1'b1, 1'b0, "sub_equal_cin_ignored");
      wait_idle(20, "idle_directed");

      // Backpressure: out_ready low for cycles 2..8 while streaming tags 0..9.
      acc = 0;
      drop_inflight = -1;
      base = out_cnt;
      for (int c = 0; c < 40 && acc < 10; c++) begin
         @(negedge clk);
         bus.out_ready = !(c >= 2 && c <= 8);
         drive_rnd(1'b1, T'(acc));
         #1;
         if (!bus.in_ready && drop_inflight < 0) drop_inflight = acc - (out_cnt - base);
         if (bus.in_ready) acc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_accepted", 128'(acc), 128'(10));
      chk("bp_held_at_stall", 128'(drop_inflight), 128'(S));
      wait_idle(40, "bp_drain");
      chk("bp_out_count", 128'(out_cnt - base), 128'(10));

      // Bubbles: input on alternate cycles, random out_ready.
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         bus.out_ready = 1'($urandom_range(0, 1));
         if (c % 2 == 0) drive_rnd(1'b1, T'(c / 2));
         else bus.in_valid = 1'b0;
      end

      // Full throughput once out_ready stays high.
      stalls = 0;
      misses = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         drive_rnd(1'b1, T'(c));
         #1;
         if (!bus.in_ready) stalls++;
         if (c >= int'(S) && !bus.out_valid) misses++;
      end
      chk("tput_stalls", 128'(stalls), 128'(0));
      chk("tput_out_gaps", 128'(misses), 128'(0));

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         drive_rnd(1'($urandom_range(0, 3) != 0), T'($urandom_range(0, 15)));
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      wait_idle(40, "rand_drain");

      // Reset with three ops in flight, the oldest parked at the output.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(1'b1, 64'd1, 64'd2, 1'b0, 1'b0, 4'd5);
      @(negedge clk);
      drive(1'b1, 64'd3, 64'd4, 1'b0, 1'b0, 4'd6);
      @(negedge clk);
      drive(1'b1, 64'd5, 64'd6, 1'b0, 1'b0, 4'd7);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 128'(bus.out_valid), 128'(1'b1));
      chk("pre_rst_sum", 128'(bus.out_sum), 128'(3));
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", 128'(bus.out_valid), 128'(1'b0));
      chk("mid_rst_sum", 128'(bus.out_sum), 128'(0));
      chk("mid_rst_flags", 128'({bus.out_cout, bus.out_ovf}), 128'(0));
      chk("mid_rst_tag", 128'(bus.out_tag), 128'(0));
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      #1 chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
      bus.out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("post_rst_no_stale", 128'(stale), 128'(0));
      directed(64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 4'd9,
               64'h0000_0002_0000_0001, 1'b0, 1'b0, "post_rst_add");
      wait_idle(20, "final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
